// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
//  Shared types and helpers for the dual-response instruction cache.
//  - icache_state_t : controller states (UNC_* only reachable when the
//                     ICACHE_UNCACHED_EN macro is defined)
//  - f_tag/f_idx/f_word : address field extraction for a given geometry
// ---------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic [2:0] {
    LOOKUP      = 3'd0,
    MISS_REQ    = 3'd1,
    MISS_WAIT   = 3'd2,
    REFILL_DONE = 3'd3,
    UNC_REQ     = 3'd4,
    UNC_WAIT    = 3'd5
  } icache_state_t;

  // Tag field: everything above index+offset.
  function automatic logic [31:0] f_tag(input logic [31:0] a, input int ofs_w, input int idx_w);
    return a >> (ofs_w + idx_w);
  endfunction

  // Line index field.
  function automatic logic [31:0] f_idx(input logic [31:0] a, input int ofs_w, input int idx_w);
    return (a >> ofs_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Word-within-line field (byte offset bits [1:0] dropped).
  function automatic logic [31:0] f_word(input logic [31:0] a, input int ofs_w);
    return (a >> 2) & ((32'd1 << (ofs_w - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_data_bank.sv
// ---------------------------------------------------------------------------
// icache_data_bank
//  NSETS x WORDS_PER_LINE word store for the instruction cache. No reset:
//  contents are only observed through lines whose valid bit is set.
//  Ports:
//   i_clk                      clock
//   i_we/i_widx/i_wword/i_wdata single write port (refill)
//   i_ridx/i_rword             read address (line, word)
//   o_rdata_0                  word i_rword of line i_ridx (async)
//   o_rdata_1                  word i_rword+1, wrapping inside the line (async)
// ---------------------------------------------------------------------------
module icache_data_bank #(
  parameter  int NSETS          = 64,
  parameter  int WORDS_PER_LINE = 8,
  localparam int IDX_W          = $clog2(NSETS),
  localparam int WRD_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [WRD_W-1:0] i_wword,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  input  logic [WRD_W-1:0] i_rword,
  output logic [31:0]      o_rdata_0,
  output logic [31:0]      o_rdata_1
);

  logic [31:0]      r_mem [NSETS][WORDS_PER_LINE];
  logic [WRD_W-1:0] w_rword1;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx][i_wword] <= i_wdata;
  end

  // Wraps on the last word; the top level never reports that word as valid.
  assign w_rword1  = i_rword + WRD_W'(1);
  assign o_rdata_0 = r_mem[i_ridx][i_rword];
  assign o_rdata_1 = r_mem[i_ridx][w_rword1];

endmodule

// File: rtl/icache_dual_resp.sv
// ---------------------------------------------------------------------------
// icache_dual_resp
//  Direct-mapped read-only instruction cache answering a dual-issue fetch
//  stage. A hit returns inst_addr_1 and (unless it is the last word of the
//  line) the following word in the same cycle. A miss refills the whole line
//  word by word over an SRAM-like bus, then re-looks-up.
//  Optional feature macro: ICACHE_UNCACHED_EN -- kseg1 (addr[31:29]==3'b101)
//  fetches bypass the cache with a single-word bus read.
//  Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   inst_req, inst_addr_1/2          fetch request (addr_2 = addr_1+4)
//   inst_data_ok, second_data_ok     word 1 valid / word 2 also valid
//   inst_rdata_1/2                   returned words (0 when not valid)
//   mem_req, mem_addr                refill word request toward the bridge
//   mem_addr_ok, mem_data_ok         request accepted / data returned
//   mem_rdata                        returned word
// ---------------------------------------------------------------------------
module icache_dual_resp
  import icache_pkg::*;
#(
  parameter int NSETS          = 64,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr_1,
  input  logic [31:0] inst_addr_2,
  output logic        inst_data_ok,
  output logic        second_data_ok,
  output logic [31:0] inst_rdata_1,
  output logic [31:0] inst_rdata_2,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int OFS_W = $clog2(WORDS_PER_LINE) + 2;
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - IDX_W - OFS_W;
  localparam int WRD_W = OFS_W - 2;
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(WORDS_PER_LINE - 1);

  icache_state_t    r_state;
  logic [WRD_W-1:0] r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [NSETS-1:0] r_valid;
  logic [TAG_W-1:0] r_tags [NSETS];
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [WRD_W-1:0] w_word, w_cnt_nxt;
  logic             w_unc, w_lookup, w_hit, w_miss, w_sec, w_we;
  logic [31:0]      w_rd0, w_rd1;
  logic             w_unused;

  assign w_tag  = TAG_W'(f_tag(inst_addr_1, OFS_W, IDX_W));
  assign w_idx  = IDX_W'(f_idx(inst_addr_1, OFS_W, IDX_W));
  assign w_word = WRD_W'(f_word(inst_addr_1, OFS_W));

  // Second port of the bank already supplies word+1 of the same line, so
  // inst_addr_2 carries no extra information.
  assign w_unused = ^{inst_addr_2, inst_addr_1[1:0]};

`ifdef ICACHE_UNCACHED_EN
  assign w_unc = (inst_addr_1[31:29] == 3'b101);
`else
  assign w_unc = 1'b0;
`endif

  assign w_lookup  = (r_state == LOOKUP) & inst_req & ~w_unc;
  assign w_hit     = w_lookup & r_valid[w_idx] & (r_tags[w_idx] == w_tag);
  assign w_miss    = w_lookup & ~w_hit;
  assign w_sec     = w_hit & (w_word != LAST_WORD);
  assign w_we      = (r_state == MISS_WAIT) & mem_data_ok;
  assign w_cnt_nxt = r_cnt + WRD_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= LOOKUP;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_valid    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        LOOKUP: begin
          if (w_miss) begin
            r_state    <= MISS_REQ;
            r_cnt      <= '0;
            r_tag      <= w_tag;
            r_idx      <= w_idx;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_tag, w_idx, {WRD_W{1'b0}}, 2'b00};
          end
`ifdef ICACHE_UNCACHED_EN
          else if (inst_req && w_unc) begin
            r_state    <= UNC_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= inst_addr_1;
          end
`endif
        end
        MISS_REQ: begin
          // A same-cycle data_ok is not consumed here; only one request is
          // ever outstanding, so data is taken in MISS_WAIT.
          if (mem_addr_ok) begin
            r_state   <= MISS_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        MISS_WAIT: begin
          if (mem_data_ok) begin
            if (r_cnt == LAST_WORD) begin
              r_state <= REFILL_DONE;
            end else begin
              r_state    <= MISS_REQ;
              r_cnt      <= w_cnt_nxt;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {r_tag, r_idx, w_cnt_nxt, 2'b00};
            end
          end
        end
        REFILL_DONE: begin
          r_valid[r_idx] <= 1'b1;
          r_state        <= LOOKUP;
        end
`ifdef ICACHE_UNCACHED_EN
        UNC_REQ: begin
          if (mem_addr_ok) begin
            r_state   <= UNC_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        UNC_WAIT: begin
          if (mem_data_ok) r_state <= LOOKUP;
        end
`endif
        default: r_state <= LOOKUP;
      endcase
    end
  end

  // Tag store is reset-free; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (resetn && r_state == REFILL_DONE) r_tags[r_idx] <= r_tag;
  end

  icache_data_bank #(
    .NSETS          (NSETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_bank (
    .i_clk     (clk),
    .i_we      (w_we),
    .i_widx    (r_idx),
    .i_wword   (r_cnt),
    .i_wdata   (mem_rdata),
    .i_ridx    (w_idx),
    .i_rword   (w_word),
    .o_rdata_0 (w_rd0),
    .o_rdata_1 (w_rd1)
  );

  // Data outputs gated to 0 so reset-free array contents never leak out.
  always_comb begin
    inst_data_ok   = w_hit;
    second_data_ok = w_sec;
    inst_rdata_1   = w_hit ? w_rd0 : 32'd0;
    inst_rdata_2   = w_sec ? w_rd1 : 32'd0;
`ifdef ICACHE_UNCACHED_EN
    if (r_state == UNC_WAIT && mem_data_ok) begin
      inst_data_ok = 1'b1;
      inst_rdata_1 = mem_rdata;
    end
`endif
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule
